// File: rtl/rca_pkg.sv
// rca_pkg: shared width default and bundled result type for the ripple-carry adder
package rca_pkg;
    localparam int RCA_DEFAULT_WIDTH = 4;
    typedef struct packed {
        logic [RCA_DEFAULT_WIDTH-1:0] sum;
        logic                         carry;
        logic                         overflow;
    } rca_result_t;
endpackage

// File: rtl/rca_full_adder.sv
// full_adder: single-bit combinational full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/rca.sv
// rca: ripple-carry adder with registered sum, carry-out and signed overflow
module rca
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = Cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                sum      <= s;
                carry    <= c[WIDTH];
                overflow <= c[WIDTH] ^ c[WIDTH-1];
            end
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_rca.sv
// tb_rca: table-driven, exhaustive and randomized checks of rca against an arithmetic model
module tb_rca;
    logic       clk = 1'b0;
    logic       rst_n, Cin, in_valid;
    logic [3:0] a, b;
    logic [3:0] sum;
    logic       carry, overflow, out_valid;
    int         total = 0;
    int         bad = 0;
    logic [3:0] m_sum;
    logic       m_carry, m_ovf, m_valid;

    rca #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .Cin      (Cin),
        .in_valid (in_valid),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] va, vb;
        logic       vc, vv, vr;
        logic [3:0] es;
        logic       ec, eo, ev;
    } vec_t;

    task automatic step(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                        input logic iv, input logic ir);
        int t, sa, sb, ss;
        a = ia; b = ib; Cin = ic; in_valid = iv; rst_n = ir;
        @(posedge clk);
        #1;
        t  = int'(ia) + int'(ib) + int'(ic);
        sa = (ia > 7) ? int'(ia) - 16 : int'(ia);
        sb = (ib > 7) ? int'(ib) - 16 : int'(ib);
        ss = sa + sb + int'(ic);
        if (!ir) begin
            m_sum = 0; m_carry = 0; m_ovf = 0; m_valid = 0;
        end else begin
            if (iv) begin
                m_sum   = 4'(t % 16);
                m_carry = (t >= 16);
                m_ovf   = (ss > 7) || (ss < -8);
            end
            m_valid = iv;
        end
    endtask

    task automatic chk(input string name, input logic [3:0] es, input logic ec,
                       input logic eo, input logic ev);
        total++;
        if (sum !== es || carry !== ec || overflow !== eo || out_valid !== ev) begin
            bad++;
            $display("FAIL %s: got sum=%h c=%b ovf=%b v=%b want sum=%h c=%b ovf=%b v=%b",
                     name, sum, carry, overflow, out_valid, es, ec, eo, ev);
        end
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{"rst0",  4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rst1",  4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"0+0",   4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"3+4",   4'h3, 4'h4, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"2+6",   4'h2, 4'h6, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"4+1",   4'h4, 4'h1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"15+1",  4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"15+15+1", 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"7+1",   4'h7, 4'h1, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"8+8",   4'h8, 4'h8, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1});
        foreach (vecs[i]) begin
            step(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vv, vecs[i].vr);
            chk(vecs[i].name, vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].ev);
        end

        step(4'h3, 4'h4, 1'b0, 1'b1, 1'b1);
        chk("hold_load", 4'h7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'(9 + i), 4'(2 + i), 1'b1, 1'b0, 1'b1);
            chk("hold", 4'h7, 1'b0, 1'b0, 1'b0);
        end

        step(4'h5, 4'h5, 1'b0, 1'b1, 1'b0);
        chk("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
        chk("after_rst", 4'h2, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[3:0], v[7:4], v[8], 1'b1, 1'b1);
            chk("exhaustive", m_sum, m_carry, m_ovf, m_valid);
        end

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0);
            chk("random", m_sum, m_carry, m_ovf, m_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
